// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply issue controller.
// funct3 encodings, default latency and the response entry layout.
package mul_ctrl_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam int MUL_LAT_DEF = 3;
    localparam int RD_W        = 5;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
    } rsp_t;

endpackage

// File: rtl/mul_rsp_fifo.sv
// Circular response buffer with occupancy count and synchronous clear.
// When empty the output holds the last head value that was shown.
module mul_rsp_fifo
    import mul_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(rsp_t)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Pointer and occupancy next state; clear beats push and pop
    always_comb begin
        do_push = push_i && !clr_i;
        do_pop  = pop_i && (cnt_q != '0) && !clr_i;
        wr_d    = do_push ? wrap_inc(wr_q) : wr_q;
        rd_d    = do_pop ? wrap_inc(rd_q) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    // Control registers; hold_q tracks the head while it is visible
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (cnt_q != '0) hold_q <= mem_q[rd_q];
        end
    end

    // Entry storage, written at the tail
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign valid_o = (cnt_q != '0);
    assign dout_o  = valid_o ? mem_q[rd_q] : hold_q;
    assign count_o = cnt_q;

    // Credits reserve a slot for every op in flight, so a push never meets a full buffer
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !clr_i && cnt_q == CW'(DEPTH)))
        else $error("mul_rsp_fifo push overflow");

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the fixed-latency pipelined RV32M multiplier.
// Optional perf counters (perf_issued/perf_stall) when MUL_CTRL_PERF_CNT_EN is defined.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = RD_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    input  logic             flush,
    output logic [31:0]      mul_A,
    output logic [31:0]      mul_B,
    output logic [1:0]       mul_mode,
    input  logic [63:0]      mul_product,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_rd,
    output logic [31:0]      rsp_data,
    output logic             busy
`ifdef MUL_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(MUL_LAT + FIFO_DEPTH + 1);
    localparam int EW  = TAG_W + 32;

    logic               fire;
    logic               issue;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [MUL_LAT-1:0] hi_q, hi_d;
    logic [TAG_W-1:0]   rd_q [MUL_LAT];
    logic [TAG_W-1:0]   rd_d [MUL_LAT];
    logic [CW-1:0]      pipe_cnt;
    logic [FCW-1:0]     fifo_cnt;
    logic               push;
    logic [EW-1:0]      push_ent;
    logic [EW-1:0]      head_ent;
    logic               fifo_valid;

    // Credits from registered occupancy; operands go out only on a legal issue
    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            pipe_cnt = pipe_cnt + CW'(vld_q[i]);
        end
        req_ready = !flush && ((pipe_cnt + CW'(fifo_cnt)) < CW'(FIFO_DEPTH));
        fire      = req_valid && req_ready;
        issue     = fire && !req_funct3[2];
        mul_A     = issue ? req_rs1 : '0;
        mul_B     = issue ? req_rs2 : '0;
        mul_mode  = issue ? req_funct3[1:0] : 2'b00;
        busy      = (pipe_cnt != '0) || (fifo_cnt != '0);
    end

    // Tag pipe shifts in step with the multiplier; flush kills every tag
    always_comb begin
        vld_d[0] = issue;
        rd_d[0]  = req_rd;
        hi_d[0]  = (req_funct3 != F3_MUL);
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
            hi_d[i]  = hi_q[i-1];
        end
        if (flush) vld_d = '0;
    end

    // Tag pipe registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
            hi_q  <= '0;
            for (int i = 0; i < MUL_LAT; i++) rd_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            hi_q  <= hi_d;
            for (int i = 0; i < MUL_LAT; i++) rd_q[i] <= rd_d[i];
        end
    end

    assign push     = vld_q[MUL_LAT-1];
    assign push_ent = {rd_q[MUL_LAT-1],
                       hi_q[MUL_LAT-1] ? mul_product[63:32] : mul_product[31:0]};

    mul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_rsp_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (flush),
        .push_i  (push),
        .din_i   (push_ent),
        .pop_i   (rsp_ready),
        .dout_o  (head_ent),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_rd    = head_ent[EW-1:32];
    assign rsp_data  = head_ent[31:0];

`ifdef MUL_CTRL_PERF_CNT_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    // Free-running event counters; flush leaves them alone
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_q + 32'(issue);
            perf_stall_q  <= perf_stall_q + 32'(req_valid && !req_ready);
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural multiplier.
// Optional perf ports are hooked up when MUL_CTRL_PERF_CNT_EN is defined.
module tb_mul_issue_ctrl;
    import mul_ctrl_pkg::*;

    localparam int LAT = 3;
    localparam int FD  = 4;
    localparam int TW  = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_rs1 = '0;
    logic [31:0]   req_rs2 = '0;
    logic [TW-1:0] req_rd = '0;
    logic          flush = 1'b0;
    logic [31:0]   mul_A;
    logic [31:0]   mul_B;
    logic [1:0]    mul_mode;
    logic [63:0]   mul_product;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [TW-1:0] rsp_rd;
    logic [31:0]   rsp_data;
    logic          busy;
`ifdef MUL_CTRL_PERF_CNT_EN
    logic [31:0]   perf_issued;
    logic [31:0]   perf_stall;
`endif

    always #5 CLK = ~CLK;

    mul_issue_ctrl #(.MUL_LAT(LAT), .FIFO_DEPTH(FD), .TAG_W(TW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .flush       (flush),
        .mul_A       (mul_A),
        .mul_B       (mul_B),
        .mul_mode    (mul_mode),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd      (rsp_rd),
        .rsp_data    (rsp_data),
        .busy        (busy)
`ifdef MUL_CTRL_PERF_CNT_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [63:0] mulref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] m);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    logic [63:0] p_q [LAT];
    always @(posedge CLK) begin
        p_q[0] <= mulref(mul_A, mul_B, mul_mode);
        for (int i = 1; i < LAT; i++) p_q[i] <= p_q[i-1];
    end
    assign mul_product = p_q[LAT-1];

    typedef struct {
        logic [TW-1:0] rd;
        logic [31:0]   data;
        int            iss;
        bit            exact;
    } sb_t;

    sb_t         sb[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          outst = 0;
    int          nvalid = 0;
    bit          rand_rr = 0;
    bit          last_fire = 0;
    logic [31:0] cur_exp = '0;
    bit          cur_exact = 0;
    logic [TW-1:0] last_rd = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic fire;
        logic legal;
        logic pop;
        bit   popped;
        sb_t  e;
        popped = 0;
        if (rand_rr) rsp_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("req_ready", 64'(req_ready), 64'(!flush && (outst < FD)));
        chk("busy", 64'(busy), 64'(outst != 0));
        fire = req_valid && req_ready;
        legal = !req_funct3[2];
        last_fire = fire;
        if (fire && legal) begin
            chk("mul_A", 64'(mul_A), 64'(req_rs1));
            chk("mul_B", 64'(mul_B), 64'(req_rs2));
            chk("mul_mode", 64'(mul_mode), 64'(req_funct3[1:0]));
            sb.push_back('{req_rd, cur_exp, cyc, cur_exact});
        end else if (!fire) begin
            chk("mul_A_idle", 64'(mul_A), 64'(0));
            chk("mul_mode_idle", 64'(mul_mode), 64'(0));
        end
        if (rsp_valid) nvalid++;
        pop = rsp_valid && rsp_ready && !flush;
        if (!rsp_valid) begin
            chk("hold_rd", 64'(rsp_rd), 64'(last_rd));
            chk("hold_data", 64'(rsp_data), 64'(last_data));
        end else if (sb.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid), 64'(0));
        end else if (pop) begin
            e = sb.pop_front();
            popped = 1;
            chk("rsp_rd", 64'(rsp_rd), 64'(e.rd));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            if (e.exact) chk("latency", 64'(cyc - e.iss), 64'(LAT + 1));
            else chk("latency_min", 64'((cyc - e.iss) >= LAT + 1), 64'(1));
            last_rd = e.rd;
            last_data = e.data;
        end
        @(posedge CLK);
        cyc++;
        if (flush) begin
            sb.delete();
            outst = 0;
        end else begin
            outst = outst + int'(fire && legal) - int'(popped);
        end
        #1;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] rd, input logic [31:0] exp, input bit exact);
        bit fired;
        fired = 0;
        req_valid = 1'b1;
        req_funct3 = f3;
        req_rs1 = a;
        req_rs2 = b;
        req_rd = rd;
        cur_exp = exp;
        cur_exact = exact;
        for (int i = 0; i < 40 && !fired; i++) begin
            tick();
            fired = last_fire;
        end
        chk("send_fire", 64'(fired), 64'(1));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rr = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'(0));
        tick();
        tick();
    endtask

    task automatic set_bp(input int n);
        req_funct3 = F3_MUL;
        req_rs1 = 32'(20 + n);
        req_rs2 = 32'd3;
        req_rd = TW'(10 + n);
        cur_exp = 32'((20 + n) * 3);
        cur_exact = 0;
    endtask

    initial begin
        int          nacc;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;

        repeat (2) @(negedge CLK);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rd", 64'(rsp_rd), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mul_A", 64'(mul_A), 64'(0));
        RST = 1'b0;
        @(posedge CLK);
        #1;
        tick();

        send(F3_MUL, 32'd7, 32'd6, 5'd3, 32'h0000002A, 1);
        drain();

        send(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 0);
        send(F3_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd5, 32'hFFFFFFFF, 0);
        send(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h00000000, 0);
        send(F3_MULH, 32'h80000000, 32'h80000000, 5'd7, 32'h40000000, 0);
        drain();

        for (int i = 1; i <= 8; i++) begin
            send(F3_MUL, 32'(i), 32'(i + 100), TW'(i), 32'(i * (i + 100)), 0);
        end
        drain();

        rsp_ready = 1'b0;
        nacc = 0;
        set_bp(nacc);
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_fire) begin
                nacc++;
                set_bp(nacc);
            end
        end
        chk("bp_accepted", 64'(nacc), 64'(4));
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && nacc < 6; i++) begin
            tick();
            if (last_fire) begin
                nacc++;
                set_bp(nacc);
            end
        end
        req_valid = 1'b0;
        chk("bp_total", 64'(nacc), 64'(6));
        drain();

        send(F3_MUL, 32'd2, 32'd2, 5'd1, 32'd4, 0);
        send(F3_MUL, 32'd3, 32'd2, 5'd2, 32'd6, 0);
        send(F3_MUL, 32'd4, 32'd2, 5'd3, 32'd8, 0);
        nvalid = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        chk("flush_no_rsp", 64'(nvalid), 64'(0));
        send(F3_MUL, 32'd3, 32'd3, 5'd9, 32'd9, 1);
        drain();

        send(3'b100, 32'd5, 32'd5, 5'd12, 32'd0, 0);
        send(3'b111, 32'd5, 32'd5, 5'd13, 32'd0, 0);
        repeat (6) tick();

        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(F3_MUL, 32'(i + 1), 32'd5, TW'(20 + i), 32'((i + 1) * 5), 0);
        end
        tick();
        chk("pre_rst_valid", 64'(rsp_valid), 64'(1));
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_rsp_rd", 64'(rsp_rd), 64'(0));
        chk("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_mul_B", 64'(mul_B), 64'(0));
        chk("mid_rst_mode", 64'(mul_mode), 64'(0));
        sb.delete();
        outst = 0;
        last_rd = '0;
        last_data = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        repeat (10) tick();

        rand_rr = 1;
        for (int k = 0; k < 40; k++) begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd4) f3 = 3'($urandom_range(4, 7));
            a = $urandom;
            b = $urandom;
            p = mulref(a, b, f3[1:0]);
            send(f3, a, b, TW'($urandom_range(0, 31)),
                 (f3 == F3_MUL) ? p[31:0] : p[63:32], 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
